// File: rtl/mxrv_if_prefetch_if.sv
// Bus bundle for the instruction prefetch unit.
// ROM side: req_valid_o/req_addr_o/req_ready_i request handshake and
//           rsp_valid_i/rsp_data_i in-order responses.
// Decode side: inst_valid_o/inst_o/inst_addr_o/inst_ready_i FIFO head.
// master: the prefetch unit; slave: the ROM + decode environment.
interface mxrv_if_prefetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid_o;
  logic [ADDR_W-1:0] req_addr_o;
  logic              req_ready_i;
  logic              rsp_valid_i;
  logic [DATA_W-1:0] rsp_data_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_ready_i;

  modport master (
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i
  );
endinterface

// File: rtl/mxrv_if_prefetch.sv
// Instruction prefetch unit: keeps up to MAX_OUTST ROM reads in flight and
// buffers returned words with their addresses in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   jump_flag_i/addr_i  fetch redirect (highest priority)
//   hold_flag_i         stall issue and output
//   bus (master)        ROM request/response and decode-side FIFO head
//   fifo_count_o        FIFO occupancy
module mxrv_if_prefetch #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     jump_flag_i,
  input  logic [ADDR_W-1:0]        jump_addr_i,
  input  logic                     hold_flag_i,
  mxrv_if_prefetch_if.master       bus,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned AQ_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [OUT_W-1:0]  outstanding, out_next;
  logic [OUT_W-1:0]  drop_cnt, drop_next;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] aq [MAX_OUTST];
  logic [AQ_W-1:0]   aq_wr, aq_rd;

  logic jump_act, req_fire, push, pop, has_credit;

  function automatic logic [AQ_W-1:0] aq_inc(input logic [AQ_W-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + AQ_W'(1);
  endfunction

  assign jump_act   = jump_flag_i && (state != S_IDLE);
  assign has_credit = (32'(outstanding) < MAX_OUTST) &&
                      (32'(count) + 32'(outstanding) < DEPTH);

  assign bus.req_valid_o  = (state == S_FETCH) && !hold_flag_i && !jump_flag_i && has_credit;
  assign bus.req_addr_o   = fetch_pc;
  assign req_fire         = bus.req_valid_o && bus.req_ready_i;

  assign bus.inst_valid_o = (count != '0) && !hold_flag_i && !jump_flag_i;
  assign bus.inst_o       = (count != '0) ? fifo_data[rd_ptr] : '0;
  assign bus.inst_addr_o  = (count != '0) ? fifo_addr[rd_ptr] : '0;
  assign fifo_count_o     = count;

  // A response is stale if a drain is pending or a jump lands in the same cycle.
  assign push = bus.rsp_valid_i && (drop_cnt == '0) && !jump_act;
  assign pop  = bus.inst_valid_o && bus.inst_ready_i;

  always_comb begin
    out_next  = outstanding + OUT_W'(req_fire) - OUT_W'(bus.rsp_valid_i);
    drop_next = drop_cnt;
    if (jump_act)
      drop_next = out_next;
    else if (bus.rsp_valid_i && (drop_cnt != '0))
      drop_next = drop_cnt - OUT_W'(1);
  end

  // drop_cnt is always zero in FETCH unless a jump just loaded it, so the
  // FETCH/DRAIN choice reduces to whether stale responses remain.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH,
      S_DRAIN: state_next = (drop_next != '0) ? S_DRAIN : S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      drop_cnt    <= drop_next;
      if (jump_act)
        fetch_pc <= jump_addr_i & ~ADDR_W'(3);
      else if (req_fire)
        fetch_pc <= fetch_pc + ADDR_W'(4);
      if (req_fire)
        aq_wr <= aq_inc(aq_wr);
      if (bus.rsp_valid_i)
        aq_rd <= aq_inc(aq_rd);
      if (jump_act) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      aq[aq_wr] <= fetch_pc;
    if (push) begin
      fifo_data[wr_ptr] <= bus.rsp_data_i;
      fifo_addr[wr_ptr] <= aq[aq_rd];
    end
  end

endmodule

// File: tb/tb_mxrv_if_prefetch.sv
module tb_mxrv_if_prefetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump_flag, hold_flag;
  logic [31:0] jump_addr;
  logic [2:0] fifo_count;
  logic jump2 = 1'b0, hold2 = 1'b0;
  logic [31:0] jaddr2 = '0;
  logic [2:0] fifo_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mxrv_if_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mxrv_if_prefetch_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  mxrv_if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUTST(2),
                     .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .hold_flag_i(hold_flag), .bus(bus), .fifo_count_o(fifo_count));

  mxrv_if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_OUTST(2),
                     .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .jump_flag_i(jump2), .jump_addr_i(jaddr2),
    .hold_flag_i(hold2), .bus(bus2), .fifo_count_o(fifo_count2));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wrap-around instance: 1-cycle ROM, decode always ready.
  logic [31:0] q2req[$];
  logic [31:0] q2inst[$];
  initial begin
    bus2.req_ready_i  = 1'b1;
    bus2.inst_ready_i = 1'b1;
    bus2.rsp_data_i   = '0;
  end
  always_ff @(posedge clk)
    bus2.rsp_valid_i <= rst_n && bus2.req_valid_o && bus2.req_ready_i;
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (bus2.req_valid_o) q2req.push_back(bus2.req_addr_o);
      if (bus2.inst_valid_o) q2inst.push_back(bus2.inst_addr_o);
    end
  end

  // No write may land in a full FIFO unless the head leaves in the same cycle.
  always @(negedge clk) begin
    #2;
    if (rst_n === 1'b1 && u_dut.push && !u_dut.pop && u_dut.count == 3'd4) begin
      n_err++;
      $display("FAIL fifo_overflow: count %0d with push and no pop", u_dut.count);
    end
  end

  typedef struct {
    logic jump; logic [31:0] jaddr; logic hold; logic rdy;
    logic rspv; logic [31:0] rspd; logic irdy;
    logic e_rv; logic [31:0] e_ra; logic e_iv; logic [31:0] e_ia; logic [2:0] e_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic jump, input logic [31:0] jaddr, input logic hold,
                             input logic rdy, input logic rspv, input logic [31:0] rspd,
                             input logic irdy, input logic e_rv, input logic [31:0] e_ra,
                             input logic e_iv, input logic [31:0] e_ia, input logic [2:0] e_cnt);
    vec_t r;
    r.jump = jump; r.jaddr = jaddr; r.hold = hold; r.rdy = rdy; r.rspv = rspv;
    r.rspd = rspd; r.irdy = irdy; r.e_rv = e_rv; r.e_ra = e_ra; r.e_iv = e_iv;
    r.e_ia = e_ia; r.e_cnt = e_cnt;
    return r;
  endfunction

  typedef struct { logic [31:0] a; int unsigned t; } pend_t;
  pend_t romq[$];

  initial begin
    jump_flag = 0; jump_addr = '0; hold_flag = 0;
    bus.req_ready_i = 1; bus.rsp_valid_i = 0; bus.rsp_data_i = '0; bus.inst_ready_i = 1;

    //      jmp jaddr        hld rdy rv  rspd           irdy  erv era          eiv eia          cnt
    // steady flow from reset
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   0, 32'h0,     0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   1, 32'h0,     0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h0),    1,   1, 32'h4,     0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h4),    1,   1, 32'h8,     1, 32'h0,        1));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h8),    1,   1, 32'hC,     1, 32'h4,        1));
    // decode stops: credit check fills the FIFO exactly
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'hC),    0,   1, 32'h10,    1, 32'h8,        1));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h10),   0,   1, 32'h14,    1, 32'h8,        2));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h14),   0,   0, 32'h18,    1, 32'h8,        3));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             0,   0, 32'h18,    1, 32'h8,        4));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   0, 32'h18,    1, 32'h8,        4));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             0,   1, 32'h18,    1, 32'hC,        3));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h18),   0,   0, 32'h1C,    1, 32'hC,        3));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             0,   0, 32'h1C,    1, 32'hC,        4));
    // drain, then jump with two reads in flight
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   0, 32'h1C,    1, 32'hC,        4));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   1, 32'h1C,    1, 32'h10,       3));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   1, 32'h20,    1, 32'h14,       2));
    tbl.push_back(v(1, 32'h1003,     0, 1, 0, 0,             1,   0, 32'h24,    0, 0,            1));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h1C),   1,   0, 32'h1000,  0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h20),   1,   0, 32'h1000,  0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   1, 32'h1000,  0, 0,            0));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h1000), 1,   1, 32'h1004,  0, 0,            0));
    // 10-cycle hold with one response landing inside it
    tbl.push_back(v(0, 0,            1, 1, 0, 0,             1,   0, 32'h1008,  0, 0,            1));
    tbl.push_back(v(0, 0,            1, 1, 1, rom(32'h1004), 1,   0, 32'h1008,  0, 0,            1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(v(0, 0,          1, 1, 0, 0,             1,   0, 32'h1008,  0, 0,            2));
    tbl.push_back(v(0, 0,            0, 1, 0, 0,             1,   1, 32'h1008,  1, 32'h1000,     2));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h1008), 1,   1, 32'h100C,  1, 32'h1004,     1));
    tbl.push_back(v(0, 0,            0, 1, 1, rom(32'h100C), 1,   1, 32'h1010,  1, 32'h1008,     1));
    // jump with a same-cycle response: it is stale and no drain follows
    tbl.push_back(v(1, 32'h2002,     0, 1, 1, rom(32'h1010), 1,   0, 32'h1014,  0, 0,            1));
    tbl.push_back(v(0, 0,            0, 0, 0, 0,             1,   1, 32'h2000,  0, 0,            0));
    tbl.push_back(v(0, 0,            0, 0, 0, 0,             1,   1, 32'h2000,  0, 0,            0));

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
    chk("rst_req_addr", bus.req_addr_o, 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    chk("rst_inst", bus.inst_o, 32'h0);
    chk("rst_inst_addr", bus.inst_addr_o, 32'h0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_req_addr_wrap", bus2.req_addr_o, 32'hFFFF_FFF8);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = 1;
      jump_flag = tbl[i].jump; jump_addr = tbl[i].jaddr; hold_flag = tbl[i].hold;
      bus.req_ready_i = tbl[i].rdy; bus.rsp_valid_i = tbl[i].rspv;
      bus.rsp_data_i = tbl[i].rspd; bus.inst_ready_i = tbl[i].irdy;
      #1;
      chk($sformatf("row%0d_req_valid", i), 32'(bus.req_valid_o), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d_req_addr", i), bus.req_addr_o, tbl[i].e_ra);
      chk($sformatf("row%0d_inst_valid", i), 32'(bus.inst_valid_o), 32'(tbl[i].e_iv));
      chk($sformatf("row%0d_count", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_iv) begin
        chk($sformatf("row%0d_inst_addr", i), bus.inst_addr_o, tbl[i].e_ia);
        chk($sformatf("row%0d_inst", i), bus.inst_o, rom(tbl[i].e_ia));
      end
    end

    // PC wrap on the second instance
    if (q2req.size() < 4) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_req_count: got %0d expected >= 4", q2req.size());
    end else begin
      chk("wrap_req0", q2req[0], 32'hFFFF_FFF8);
      chk("wrap_req1", q2req[1], 32'hFFFF_FFFC);
      chk("wrap_req2", q2req[2], 32'h0000_0000);
      chk("wrap_req3", q2req[3], 32'h0000_0004);
    end
    if (q2inst.size() < 3) begin
      n_cmp++; n_err++;
      $display("FAIL wrap_inst_count: got %0d expected >= 3", q2inst.size());
    end else begin
      chk("wrap_inst0", q2inst[0], 32'hFFFF_FFF8);
      chk("wrap_inst1", q2inst[1], 32'hFFFF_FFFC);
      chk("wrap_inst2", q2inst[2], 32'h0000_0000);
    end

    // random ROM timing, back-pressure, holds and jumps
    @(negedge clk);
    rst_n = 0; jump_flag = 0; hold_flag = 0; bus.rsp_valid_i = 0;
    repeat (2) @(negedge clk);
    begin
      logic [31:0] exp_req, exp_inst;
      int unsigned cyc, pops, last_t;
      exp_req = '0; exp_inst = '0; cyc = 0; pops = 0; last_t = 0;
      romq.delete();
      rst_n = 1;
      while (pops < 500 && cyc < 20000) begin
        if (cyc != 0) @(negedge clk);
        cyc++;
        bus.rsp_valid_i = 0;
        bus.rsp_data_i = '0;
        if (romq.size() > 0 && romq[0].t <= cyc) begin
          bus.rsp_valid_i = 1;
          bus.rsp_data_i = rom(romq[0].a);
        end
        bus.req_ready_i = 1'($urandom_range(0, 1));
        bus.inst_ready_i = ($urandom_range(0, 3) != 0);
        hold_flag = (cyc > 3) && ($urandom_range(0, 15) == 0);
        jump_flag = (cyc > 3) && ($urandom_range(0, 39) == 0);
        jump_addr = $urandom;
        #1;
        if (hold_flag || jump_flag)
          chk("rand_blocked_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        if (jump_flag) begin
          chk("rand_jump_req_valid", 32'(bus.req_valid_o), 32'd0);
          exp_req = jump_addr & ~32'd3;
          exp_inst = jump_addr & ~32'd3;
        end else begin
          if (bus.req_valid_o && bus.req_ready_i) begin
            pend_t p;
            chk("rand_req_addr", bus.req_addr_o, exp_req);
            p.a = bus.req_addr_o;
            p.t = cyc + $urandom_range(1, 3);
            if (p.t < last_t) p.t = last_t;
            last_t = p.t;
            romq.push_back(p);
            exp_req += 32'd4;
          end
          if (bus.inst_valid_o && bus.inst_ready_i) begin
            chk("rand_inst_addr", bus.inst_addr_o, exp_inst);
            chk("rand_inst", bus.inst_o, rom(exp_inst));
            exp_inst += 32'd4;
            pops++;
          end
        end
        if (bus.rsp_valid_i) void'(romq.pop_front());
      end
      chk("rand_pop_budget", pops, 32'd500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mxrv_if_prefetch.md
Name: mxrv_if_prefetch

Overview:
Parametrised instruction prefetch unit, the next generation of the single-request fetch path. It sits between the PC/control logic and the instruction ROM and keeps up to MAX_OUTST read requests in flight. Returned instructions are buffered with their addresses in a DEPTH-entry FIFO for the decode stage. It handles jump redirection, discarding stale in-flight responses, and hold stalls without losing data.

Parameters:
ADDR_W, 32, address width of the PC and the ROM request address
DATA_W, 32, instruction word width
DEPTH, 4, instruction FIFO entries; power of two, at least 2
MAX_OUTST, 2, maximum outstanding ROM requests; 1 to DEPTH
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  synchronous reset, active-low
jump_flag_i  in  1  redirect fetch; has priority over every other input
jump_addr_i  in  ADDR_W  redirect target; bits [1:0] are forced to 0
hold_flag_i  in  1  stall: no new requests and no instruction output
req_valid_o  out  1  ROM read request valid
req_addr_o  out  ADDR_W  ROM read address
req_ready_i  in  1  ROM accepts the request when req_valid_o & req_ready_i
rsp_valid_i  in  1  ROM response valid; responses are in order and always accepted
rsp_data_i  in  DATA_W  ROM instruction data
inst_valid_o  out  1  FIFO head is valid toward decode
inst_o  out  DATA_W  head instruction
inst_addr_o  out  ADDR_W  head instruction address
inst_ready_i  in  1  decode pops the head when inst_valid_o & inst_ready_i
fifo_count_o  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, fetch_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - All outputs are 0; req_addr_o shows fetch_pc.
- States:
  - IDLE -> FETCH unconditionally on the next cycle.
  - FETCH -> DRAIN on jump when outstanding (after this cycle's responses) is nonzero; otherwise FETCH stays in FETCH with the new pc.
  - DRAIN -> FETCH when drop_cnt reaches 0.
- Request issue:
  - req_valid_o = (state==FETCH) & !hold_flag_i & !jump_flag_i & (outstanding < MAX_OUTST) & (count + outstanding < DEPTH).
  - Credit check ensures a FIFO overflow is impossible.
  - On handshake: fetch_pc += 4, wrapping modulo 2^ADDR_W; outstanding++; issued address pushed into an internal MAX_OUTST-entry address queue.
  - req_valid_o may drop without handshake; the ROM must tolerate this.
- Response, not dropping (drop_cnt==0): push {addr_queue head, rsp_data_i} into the FIFO, pop the address queue, outstanding--.
- Response while drop_cnt>0: data is discarded, drop_cnt--, outstanding--, address queue popped.
- Request and response in the same cycle: outstanding is unchanged.
- Output:
  - inst_valid_o = FIFO non-empty & !hold_flag_i & !jump_flag_i.
  - The FIFO is registered: a response in cycle N is visible at the output in cycle N+1.
  - Minimum latency from request handshake to inst_valid_o, with a 1-cycle ROM, is 2 cycles.
- Hold:
  - Blocks issue and output only.
  - In-flight responses are still written to the FIFO.
  - FIFO content and fetch_pc are preserved.
- Jump, in any state except IDLE:
  - Same cycle: FIFO cleared, any pop ignored, fetch_pc <= {jump_addr_i[ADDR_W-1:2], 2'b00}.
  - drop_cnt <= outstanding after accounting for this cycle's response; a same-cycle response counts as stale and is discarded.
  - Jump during DRAIN reloads fetch_pc and keeps the remaining drop count.
- Simultaneous push and pop when the FIFO is full: legal, and the count is unchanged.
- Push into a full FIFO cannot occur; a bench assertion checks this.
- Reset mid-operation: all state is cleared. Any later rsp_valid_i not preceded by a new request is a ROM protocol error.

Test Plan:
1. Reset release, ROM with ready=1 and 1-cycle response, inst_ready=1 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; first inst_valid_o 2 cycles after the first request, inst_addr_o=0x0; then one instruction per cycle.
2. inst_ready=0, DEPTH=4 -> exactly 4 requests issued, fifo_count_o=4, req_valid_o=0; one pop -> exactly one new request issued.
3. jump_flag_i=1 with jump_addr_i=0x1003 while 2 requests are outstanding -> FIFO empty, next request to 0x1000 only after both stale responses return; neither stale response ever appears on inst_o.
4. hold_flag_i=1 for 10 cycles with 1 response in flight -> no request and inst_valid_o=0 during hold, fifo_count_o increases by 1; after release, output resumes in address order.
5. RESET_PC=0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; pc wraps around.
6. ROM req_ready_i random at 50%, response latency random from 1 to 3, 500 instructions, random jumps -> output addresses strictly sequential between jumps; each post-jump stream starts at the aligned target.
